tamagotchi_sensor_conditioner: RTL and testbench

//  Conditions the three raw pet-sensor inputs (LDR comparator, microphone comparator, tilt/PIR switch)

---
 rtl/tamagotchi_sensor_conditioner.sv | 198 +++++++++++++++++++
 tb/tb_tamagotchi_sensor_conditioner.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tamagotchi_sensor_conditioner.sv
// rtl/tamagotchi_sensor_conditioner.sv - synchronise, debounce and stretch the pet sensor inputs
//
// Purpose:
//   Turns three raw, asynchronous pet sensors into clean levels for the pet
//   state machine. Light and movement are debounced. Sound is edge-detected
//   and stretched. Movement events, which are either edge of the debounced
//   switch, are stretched. activity_pulse flags any output that goes 0->1.
//
// Ports:
//   clk                in   system clock
//   rst                in   asynchronous, active-high reset (clears everything)
//   light_raw          in   LDR comparator, async, 1 = light present
//   sound_raw          in   mic comparator, async, short pulses on sound
//   move_raw           in   tilt/PIR switch, async, bouncy level
//   light_detected     out  debounced light level, registered
//   sound_detected     out  stretched sound level
//   movement_detected  out  stretched movement level
//   activity_pulse     out  one-cycle registered pulse when any *_detected rises
//
// Parameters:
//   CNT_W            width of every debounce and hold counter
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a light/move change (>=1)
//   SOUND_HOLD       cycles sound_detected stays high after the last sound edge (>=1)
//   MOVE_HOLD        cycles movement_detected stays high after the last move event (>=1)

module tamagotchi_sensor_conditioner #(
  parameter int CNT_W           = 24,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SOUND_HOLD      = 2500000,
  parameter int MOVE_HOLD       = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic light_raw,
  input  logic sound_raw,
  input  logic move_raw,
  output logic light_detected,
  output logic sound_detected,
  output logic movement_detected,
  output logic activity_pulse
);

  // Largest value a CNT_W-bit counter can hold.
  localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  // All three counts must be at least 1 and representable in CNT_W bits.
  localparam bit CNT_FITS = (DEBOUNCE_CYCLES >= 1) && (SOUND_HOLD >= 1) && (MOVE_HOLD >= 1)
                            && (64'(DEBOUNCE_CYCLES) <= CNT_MAX)
                            && (64'(SOUND_HOLD) <= CNT_MAX)
                            && (64'(MOVE_HOLD) <= CNT_MAX);

  // Terminal debounce count: reaching it with a still-differing input accepts the change.
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOUND_LOAD = CNT_W'(SOUND_HOLD);
  localparam logic [CNT_W-1:0] MOVE_LOAD  = CNT_W'(MOVE_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  cnt_fits_a: assert property (@(posedge clk) disable iff (rst) CNT_FITS)
    else $error("tamagotchi_sensor_conditioner: counts do not fit in CNT_W bits");

  // ---------------------------------------------------------------------------
  // Input synchronisers. Only the *_s2 stages feed the logic below; sound has a
  // third stage used purely for rising-edge detection.
  // ---------------------------------------------------------------------------
  logic light_s1;
  logic light_s2;
  logic sound_s1;
  logic sound_s2;
  logic sound_s3;
  logic move_s1;
  logic move_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      light_s1 <= 1'b0;
      light_s2 <= 1'b0;
      sound_s1 <= 1'b0;
      sound_s2 <= 1'b0;
      sound_s3 <= 1'b0;
      move_s1  <= 1'b0;
      move_s2  <= 1'b0;
    end else begin
      light_s1 <= light_raw;
      light_s2 <= light_s1;
      sound_s1 <= sound_raw;
      sound_s2 <= sound_s1;
      sound_s3 <= sound_s2;
      move_s1  <= move_raw;
      move_s2  <= move_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncers. Each counter measures how long the synchronised input has
  // disagreed with the accepted level; any agreement restarts the count, so a
  // change is only taken after DEBOUNCE_CYCLES consecutive differing cycles.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] dl;
  logic [CNT_W-1:0] dm;
  logic             move_db;
  logic             light_accept;
  logic             move_accept;

  assign light_accept = (light_s2 != light_detected) && (dl == DB_LAST);
  assign move_accept  = (move_s2 != move_db) && (dm == DB_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl             <= '0;
      light_detected <= 1'b0;
    end else if (light_s2 == light_detected) begin
      dl <= '0;
    end else if (light_accept) begin
      light_detected <= light_s2;
      dl             <= '0;
    end else begin
      dl <= dl + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm      <= '0;
      move_db <= 1'b0;
    end else if (move_s2 == move_db) begin
      dm <= '0;
    end else if (move_accept) begin
      move_db <= move_s2;
      dm      <= '0;
    end else begin
      dm <= dm + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Hold (pulse-stretch) counters. A load always beats the decrement, so an
  // event on the cycle the count would expire keeps the output high with no gap.
  // A move event is the cycle move_db changes in either direction, which is
  // exactly move_accept.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] hs;
  logic [CNT_W-1:0] hm;
  logic             sound_rise;

  assign sound_rise = sound_s2 & ~sound_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs <= '0;
    end else if (sound_rise) begin
      hs <= SOUND_LOAD;
    end else if (hs != '0) begin
      hs <= hs - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hm <= '0;
    end else if (move_accept) begin
      hm <= MOVE_LOAD;
    end else if (hm != '0) begin
      hm <= hm - CNT_ONE;
    end
  end

  assign sound_detected    = (hs != '0);
  assign movement_detected = (hm != '0);

  // ---------------------------------------------------------------------------
  // Activity pulse. The *_prev registers hold each output as it was one cycle
  // earlier; a rise seen this cycle is registered, so the pulse appears one
  // cycle after the output goes high and simultaneous rises merge into one.
  // ---------------------------------------------------------------------------
  logic light_prev;
  logic sound_prev;
  logic move_prev;
  logic any_rise;

  assign any_rise = (light_detected & ~light_prev)
                  | (sound_detected & ~sound_prev)
                  | (movement_detected & ~move_prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      light_prev     <= 1'b0;
      sound_prev     <= 1'b0;
      move_prev      <= 1'b0;
      activity_pulse <= 1'b0;
    end else begin
      light_prev     <= light_detected;
      sound_prev     <= sound_detected;
      move_prev      <= movement_detected;
      activity_pulse <= any_rise;
    end
  end

endmodule

// File: tb/tb_tamagotchi_sensor_conditioner.sv
// tb/tb_tamagotchi_sensor_conditioner.sv - directed and randomized self-checking bench for the sensor conditioner
`timescale 1ns/1ps

module tb_tamagotchi_sensor_conditioner;

  localparam int CNT_W = 24;
  localparam int DB    = 4;
  localparam int SH    = 10;
  localparam int MH    = 8;
  localparam int MAXN  = 16384;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic light_raw = 1'b1;
  logic sound_raw = 1'b1;
  logic move_raw  = 1'b1;
  logic light_detected;
  logic sound_detected;
  logic movement_detected;
  logic activity_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  tamagotchi_sensor_conditioner #(
    .CNT_W          (CNT_W),
    .DEBOUNCE_CYCLES(DB),
    .SOUND_HOLD     (SH),
    .MOVE_HOLD      (MH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .light_raw        (light_raw),
    .sound_raw        (sound_raw),
    .move_raw         (move_raw),
    .light_detected   (light_detected),
    .sound_detected   (sound_detected),
    .movement_detected(movement_detected),
    .activity_pulse   (activity_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw samples are logged per clock edge since reset; the
  // outputs are derived from that history with window and event-age rules.
  bit       hist_l [MAXN];
  bit       hist_s [MAXN];
  bit       hist_m [MAXN];
  int       n        = -1;
  bit       m_light  = 1'b0;
  bit       m_mdb    = 1'b0;
  int       chg_l    = -1000;
  int       chg_m    = -1000;
  int       ev_s     = -1000;
  int       ev_m     = -1000;
  bit [2:0] o_cur    = 3'b000;  // {light, sound, move} after the latest edge
  bit [2:0] o_prev   = 3'b000;  // same, one edge earlier
  bit       m_pulse  = 1'b0;
  bit       model_ok = 1'b0;

  function automatic bit raw_at(input int sig, input int k);
    if (k < 0 || k >= MAXN) return 1'b0;
    case (sig)
      0:       return hist_l[k];
      1:       return hist_s[k];
      default: return hist_m[k];
    endcase
  endfunction

  // The accepted level flips at edge 'at' when the raw value seen two edges
  // earlier has differed from it for the last DB edges, all after the last flip.
  function automatic bit debounce_flip(input int sig, input bit level, input int last_chg, input int at);
    if (at - last_chg < DB) return 1'b0;
    for (int k = at - DB + 1; k <= at; k++) begin
      if (raw_at(sig, k - 2) == level) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      n        = -1;
      m_light  = 1'b0;
      m_mdb    = 1'b0;
      chg_l    = -1000;
      chg_m    = -1000;
      ev_s     = -1000;
      ev_m     = -1000;
      o_cur    = 3'b000;
      o_prev   = 3'b000;
      m_pulse  = 1'b0;
      model_ok = 1'b1;
    end else begin
      n = n + 1;
      if (n < MAXN) begin
        hist_l[n] = light_raw;
        hist_s[n] = sound_raw;
        hist_m[n] = move_raw;
      end
      if (debounce_flip(0, m_light, chg_l, n)) begin
        m_light = !m_light;
        chg_l   = n;
      end
      if (debounce_flip(2, m_mdb, chg_m, n)) begin
        m_mdb = !m_mdb;
        chg_m = n;
        ev_m  = n;
      end
      if (raw_at(1, n - 2) && !raw_at(1, n - 3)) ev_s = n;
      m_pulse = |(o_cur & ~o_prev);
      o_prev  = o_cur;
      o_cur   = {m_light, (n - ev_s) < SH, (n - ev_m) < MH};
    end
  end

  // Cycle-by-cycle comparison against the model, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("light_in_rst", light_detected, 1'b0);
      chk("sound_in_rst", sound_detected, 1'b0);
      chk("move_in_rst", movement_detected, 1'b0);
      chk("activity_in_rst", activity_pulse, 1'b0);
    end else if (model_ok) begin
      chk("light", light_detected, o_cur[2]);
      chk("sound", sound_detected, o_cur[1]);
      chk("move", movement_detected, o_cur[0]);
      chk("activity", activity_pulse, m_pulse);
    end
  end

  int cur;

  task automatic goto(input int k);
    while (cur < k) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic sound_run(input int gap, output int longest, output int total);
    int run;
    run     = 0;
    longest = 0;
    total   = 0;
    for (int i = 0; i < 40; i++) begin
      sound_raw = (i == 0 || i == gap);
      @(negedge clk);
      if (sound_detected) begin
        run++;
        total++;
        if (run > longest) longest = run;
      end else begin
        run = 0;
      end
    end
    sound_raw = 1'b0;
  endtask

  task automatic move_run(input bit target, input bit bounce, output int rises, output int highs, output int pulses);
    logic prev;
    prev   = movement_detected;
    rises  = 0;
    highs  = 0;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      move_raw = (bounce && i < 10) ? (i % 2 == 0) : target;
      @(negedge clk);
      if (movement_detected && !prev) rises++;
      if (movement_detected) highs++;
      if (activity_pulse) pulses++;
      prev = movement_detected;
    end
  endtask

  initial begin
    int lng;
    int tot;
    int rises;
    int highs;
    int pulses;
    int run_l;
    int run_m;

    // Reset with every raw input high, then release.
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("release_light", light_detected, 1'b0);
    chk("release_sound", sound_detected, 1'b0);
    chk("release_move", movement_detected, 1'b0);
    chk("release_activity", activity_pulse, 1'b0);
    cur = -1;
    goto(1);  chk("t1_sound_e1", sound_detected, 1'b0);
    goto(2);  chk("t1_sound_e2", sound_detected, 1'b1);
    goto(3);  chk("t1_act_e3", activity_pulse, 1'b1);
    goto(4);  chk("t1_light_e4", light_detected, 1'b0);
              chk("t1_move_e4", movement_detected, 1'b0);
    goto(5);  chk("t1_light_e5", light_detected, 1'b1);
              chk("t1_move_e5", movement_detected, 1'b1);
    goto(6);  chk("t1_act_e6", activity_pulse, 1'b1);
    goto(7);  chk("t1_act_e7", activity_pulse, 1'b0);
    goto(11); chk("t1_sound_e11", sound_detected, 1'b1);
    goto(12); chk("t1_sound_e12", sound_detected, 1'b0);
              chk("t1_move_e12", movement_detected, 1'b1);
    goto(13); chk("t1_move_e13", movement_detected, 1'b0);

    // Clean light rise from idle.
    light_raw = 1'b0;
    sound_raw = 1'b0;
    move_raw  = 1'b0;
    repeat (30) @(negedge clk);
    light_raw = 1'b1;
    cur = -1;
    goto(4); chk("t2_light_e4", light_detected, 1'b0);
    goto(5); chk("t2_light_e5", light_detected, 1'b1);
             chk("t2_act_e5", activity_pulse, 1'b0);
    goto(6); chk("t2_act_e6", activity_pulse, 1'b1);
    goto(7); chk("t2_act_e7", activity_pulse, 1'b0);

    // A light glitch one cycle shorter than the debounce window is ignored.
    light_raw = 1'b0;
    repeat (20) @(negedge clk);
    light_raw = 1'b1;
    repeat (3) @(negedge clk);
    light_raw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("t3_light_glitch", light_detected, 1'b0);
      chk("t3_act_glitch", activity_pulse, 1'b0);
    end

    // Sound stretching: single pulse, retrigger at 9 and at exactly 10 cycles.
    repeat (20) @(negedge clk);
    sound_run(-1, lng, tot);
    chk("t4_single_10", tot == 10, 1'b1);
    sound_run(9, lng, tot);
    chk("t4_retrig9_19", lng == 19, 1'b1);
    sound_run(10, lng, tot);
    chk("t4_retrig10_20", lng == 20, 1'b1);

    // Bouncy switch gives one move event; a later release gives another.
    repeat (10) @(negedge clk);
    move_run(1'b1, 1'b1, rises, highs, pulses);
    chk("t5_rise_once", rises == 1, 1'b1);
    chk("t5_high_8", highs == MH, 1'b1);
    chk("t5_one_pulse", pulses == 1, 1'b1);
    move_run(1'b0, 1'b0, rises, highs, pulses);
    chk("t5_fall_event", rises == 1, 1'b1);
    chk("t5_fall_high_8", highs == MH, 1'b1);

    // Reset while sound is stretched and the light debounce count is at 2.
    sound_raw = 1'b1;
    light_raw = 1'b1;
    cur = -1;
    goto(0);
    sound_raw = 1'b0;
    goto(3);
    chk("t6_sound_before_rst", sound_detected, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6_light_rst", light_detected, 1'b0);
    chk("t6_sound_rst", sound_detected, 1'b0);
    chk("t6_move_rst", movement_detected, 1'b0);
    chk("t6_act_rst", activity_pulse, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    cur = -1;
    goto(4); chk("t6_light_e4", light_detected, 1'b0);
    goto(5); chk("t6_light_e5", light_detected, 1'b1);

    // Randomized traffic with occasional asynchronous resets.
    run_l = 0;
    run_m = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (run_l == 0) begin
        light_raw = ($urandom_range(0, 1) == 1);
        run_l     = $urandom_range(1, 8);
      end
      run_l--;
      if (run_m == 0) begin
        move_raw = ($urandom_range(0, 1) == 1);
        run_m    = $urandom_range(1, 7);
      end
      run_m--;
      sound_raw = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 699) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
